// File: rtl/spike_fifo_writer_if.sv
// Event-FIFO write port: push strobe and index from the writer, full flag back from the FIFO.
interface spike_fifo_writer_if #(
  parameter int unsigned M = 8
) ();
  logic         FIFO_w_en_o;
  logic [M-1:0] FIFO_w_data_o;
  logic         FIFO_full_i;

  modport master (
    output FIFO_w_en_o,
    output FIFO_w_data_o,
    input  FIFO_full_i
  );

  modport slave (
    input  FIFO_w_en_o,
    input  FIFO_w_data_o,
    output FIFO_full_i
  );
endinterface

// File: rtl/spike_fifo_writer.sv
// Buffers an N-bit spike vector and, on start, pushes the index of each set bit into the
// event FIFO in ascending order, then pulses spikecore_done_o.
module spike_fifo_writer #(
  parameter int unsigned N  = 256,
  parameter int unsigned M  = $clog2(N),
  localparam int unsigned NW = N / 32,
  localparam int unsigned AW = $clog2(NW)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                start_i,
  input  logic                spk_we_i,
  input  logic [AW-1:0]       spk_waddr_i,
  input  logic [31:0]         spk_wdata_i,
  spike_fifo_writer_if.master fifo,
  output logic                spikecore_done_o,
  output logic                busy_o,
  output logic [M:0]          spike_count_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   work_q, work_d;
  logic [M:0]    cnt_q, cnt_d;
  logic [M:0]    count_q, count_d;
  logic [31:0]   buf_q [NW];
  logic [4:0]    lsb;
  logic          push;
  logic          done;

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    lsb = '0;
    for (int i = 31; i >= 0; i--) begin
      if (work_q[i]) lsb = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    push    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          widx_d  = '0;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        work_d  = buf_q[widx_q];
        state_d = StScan;
      end
      StScan: begin
        if (work_q == '0) begin
          if (widx_q == AW'(NW - 1)) begin
            state_d = StDone;
          end else begin
            widx_d  = widx_q + 1'b1;
            state_d = StLoad;
          end
        end else if (!fifo.FIFO_full_i) begin
          push   = 1'b1;
          work_d = work_q & (work_q - 32'd1);
          cnt_d  = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        count_d = cnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      widx_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // Host writes land only while idle; LOAD consumes the word it reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NW; i++) buf_q[i] <= '0;
    end else if (state_q == StIdle && spk_we_i) begin
      buf_q[spk_waddr_i] <= spk_wdata_i;
    end else if (state_q == StLoad) begin
      buf_q[widx_q] <= '0;
    end
  end

  assign fifo.FIFO_w_en_o   = push;
  assign fifo.FIFO_w_data_o = push ? {widx_q, lsb} : '0;
  assign spikecore_done_o   = done;
  assign busy_o             = (state_q != StIdle);
  assign spike_count_o      = count_q;

endmodule

// File: tb/tb_spike_fifo_writer.sv
// Bench for spike_fifo_writer: table of scan scenarios plus reset and busy-drop sequences.
module tb_spike_fifo_writer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        start_i = 1'b0;
  logic        spk_we_i = 1'b0;
  logic [2:0]  spk_waddr_i = '0;
  logic [31:0] spk_wdata_i = '0;
  logic        spikecore_done_o;
  logic        busy_o;
  logic [8:0]  spike_count_o;

  spike_fifo_writer_if #(.M(8)) fifo_if ();

  spike_fifo_writer dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .start_i          (start_i),
    .spk_we_i         (spk_we_i),
    .spk_waddr_i      (spk_waddr_i),
    .spk_wdata_i      (spk_wdata_i),
    .fifo             (fifo_if),
    .spikecore_done_o (spikecore_done_o),
    .busy_o           (busy_o),
    .spike_count_o    (spike_count_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0][31:0] words;
    bit               no_write;
    int               stall_start;
    int               stall_len;
    int               exp_done;
    int               exp_count;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [2:0] addr, input logic [31:0] data);
    @(negedge CLK);
    spk_we_i    = 1'b1;
    spk_waddr_i = addr;
    spk_wdata_i = data;
    @(posedge CLK);
    #1 spk_we_i = 1'b0;
  endtask

  // Start a scan and monitor it cycle by cycle; cycle 1 is the cycle after start is sampled.
  task automatic run_scan(input int stall_start, input int stall_len, input int inj_cyc,
                          input int rst_cyc, output int done_cyc);
    int busy_err;
    busy_err = 0;
    done_cyc = -1;
    @(negedge CLK);
    start_i = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 400; c++) begin
      #1;
      if (c == 1) start_i = 1'b0;
      fifo_if.FIFO_full_i = (c >= stall_start) && (c < stall_start + stall_len);
      if (inj_cyc != 0 && c == inj_cyc) begin
        spk_we_i    = 1'b1;
        spk_waddr_i = 3'd2;
        spk_wdata_i = 32'hFFFF_FFFF;
        start_i     = 1'b1;
      end else if (inj_cyc != 0 && c == inj_cyc + 1) begin
        spk_we_i = 1'b0;
        start_i  = 1'b0;
      end
      if (c == rst_cyc) begin
        RSTN = 1'b0;
        #1;
        check("rst_w_en", {31'b0, fifo_if.FIFO_w_en_o}, 32'd0);
        check("rst_w_data", {24'b0, fifo_if.FIFO_w_data_o}, 32'd0);
        check("rst_done", {31'b0, spikecore_done_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_count", {23'b0, spike_count_o}, 32'd0);
        exp_q.delete();
        done_cyc = c;
        break;
      end
      @(negedge CLK);
      if (!busy_o) busy_err++;
      if (fifo_if.FIFO_full_i) check("no_push_when_full", {31'b0, fifo_if.FIFO_w_en_o}, 32'd0);
      if (fifo_if.FIFO_w_en_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_push: got index %0d, expected no push", fifo_if.FIFO_w_data_o);
        end else begin
          check("push_idx", {24'b0, fifo_if.FIFO_w_data_o}, exp_q.pop_front());
        end
      end
      if (spikecore_done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge CLK);
    end
    fifo_if.FIFO_full_i = 1'b0;
    if (rst_cyc == 0) check("busy_during_scan", busy_err, 32'd0);
  endtask

  task automatic post_scan(input int done_cyc, input int exp_done, input int exp_count);
    check("done_cycle", done_cyc, exp_done);
    @(negedge CLK);
    check("done_single_pulse", {31'b0, spikecore_done_o}, 32'd0);
    check("busy_after_done", {31'b0, busy_o}, 32'd0);
    check("spike_count", {23'b0, spike_count_o}, exp_count);
    check("all_pushes_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  vec_t vecs [6];

  initial begin
    int dc;
    fifo_if.FIFO_full_i = 1'b0;

    vecs[0] = '{words: '0, no_write: 0, stall_start: 0, stall_len: 0,
                exp_done: 17, exp_count: 0};
    vecs[1] = '{words: '0, no_write: 0, stall_start: 0, stall_len: 0,
                exp_done: 20, exp_count: 3};
    vecs[1].words[0] = 32'h0000_0005;
    vecs[1].words[7] = 32'h8000_0000;
    vecs[2] = '{words: '0, no_write: 1, stall_start: 0, stall_len: 0,
                exp_done: 17, exp_count: 0};
    vecs[3] = '{words: {8{32'hFFFF_FFFF}}, no_write: 0, stall_start: 0, stall_len: 0,
                exp_done: 273, exp_count: 256};
    vecs[4] = '{words: '0, no_write: 0, stall_start: 0, stall_len: 0,
                exp_done: 19, exp_count: 2};
    vecs[4].words[3] = 32'h0000_0011;
    vecs[5] = '{words: '0, no_write: 0, stall_start: 8, stall_len: 4,
                exp_done: 23, exp_count: 2};
    vecs[5].words[3] = 32'h0000_0011;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_w_en", {31'b0, fifo_if.FIFO_w_en_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_done", {31'b0, spikecore_done_o}, 32'd0);
    check("reset_count", {23'b0, spike_count_o}, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;

    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      if (!vecs[v].no_write) begin
        for (int w = 0; w < 8; w++) write_word(3'(w), vecs[v].words[w]);
      end
      for (int w = 0; w < 8; w++)
        for (int b = 0; b < 32; b++)
          if (vecs[v].words[w][b]) exp_q.push_back(w * 32 + b);
      run_scan(vecs[v].stall_start, vecs[v].stall_len, 0, 0, dc);
      post_scan(dc, vecs[v].exp_done, vecs[v].exp_count);
    end

    // Reset after two pushes with bits still pending in work and in the buffer.
    write_word(3'd0, 32'h0000_000F);
    write_word(3'd1, 32'h0000_0001);
    exp_q = '{0, 1, 2, 3, 32};
    run_scan(0, 0, 0, 4, dc);
    @(negedge CLK);
    RSTN = 1'b1;
    run_scan(0, 0, 0, 0, dc);
    post_scan(dc, 17, 0);

    // Write and start while busy are dropped; word2 stays empty for the next scan.
    run_scan(0, 0, 6, 0, dc);
    post_scan(dc, 17, 0);
    run_scan(0, 0, 0, 0, dc);
    post_scan(dc, 17, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_fifo_writer.md
Name: spike_fifo_writer

Overview:
Producer side of the spike-event FIFO. It buffers an N-bit input spike vector, written as 32-bit words by the host or spike source. On start it scans the vector from lowest to highest index and pushes the M-bit index of every set bit into the event FIFO, one entry per cycle, stalling while the FIFO is full. When the scan completes it pulses spikecore_done_o, which the downstream neuron-update controller waits on before draining the FIFO.

Parameters:
N, 256, number of neurons / spike-vector bits; multiple of 32
M, 8, neuron index width; N = 2^M
W, 32, spike buffer word width (fixed)
NW, N/W (8), number of buffer words; address width AW = log2(NW) (3)

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous, active-low reset
start_i  in  1  scan request; sampled only in IDLE
spk_we_i  in  1  spike buffer word write strobe
spk_waddr_i  in  AW  spike buffer word address
spk_wdata_i  in  32  spike word; bit b of word w = neuron w*32+b
FIFO_w_en_o  out  1  FIFO push strobe
FIFO_w_data_o  out  M  neuron index pushed
FIFO_full_i  in  1  FIFO full; no push permitted while high
spikecore_done_o  out  1  one-cycle pulse at end of scan
busy_o  out  1  high in every state except IDLE
spike_count_o  out  M+1  number of pushes in the last completed scan

Behaviour:
- Reset: FSM=IDLE; buffer, working word, word index, push counter and spike_count_o are all 0. FIFO_w_en_o, spikecore_done_o and busy_o are 0.
- Buffer write: when spk_we_i=1 in IDLE, buf[spk_waddr_i] <= spk_wdata_i at the next edge. spk_we_i while busy_o=1 is ignored; the data is dropped.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE: if start_i=1, then LOAD, widx<=0, push counter<=0. Otherwise stay in IDLE.
- LOAD: work<=buf[widx]; buf[widx]<=0 (the buffer is consumed); next state SCAN.
- SCAN, work==0: if widx==NW-1 go to DONE; else widx<=widx+1 and go to LOAD.
- SCAN, work!=0 and FIFO_full_i=0:
  - FIFO_w_en_o=1 (combinational in the same cycle).
  - FIFO_w_data_o = {widx, lsb}, where lsb = index of the lowest set bit of work.
  - At the edge: clear that bit in work, push counter +1, stay in SCAN.
- SCAN, work!=0 and FIFO_full_i=1: FIFO_w_en_o=0; hold all state and stay in SCAN.
- DONE: spikecore_done_o=1 for exactly this cycle; spike_count_o<=push counter; next state IDLE.
- FIFO_w_data_o outside a push cycle: drive 0.
- start_i outside IDLE is ignored. start_i held high re-triggers a scan on the cycle after DONE returns to IDLE.
- Timing: with start_i sampled at edge 0, LOAD0 occurs in cycle 1. For an all-zero vector, DONE is in cycle 2*NW+1 = 17. Each set bit adds 1 cycle; each FIFO_full_i=1 cycle during a pending push adds 1 cycle.
- Ordering: indices are pushed strictly ascending. No duplicates; no lost bits.
- Push counter is M+1 bits, so N=256 (all bits set) is representable without wrap.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values; buffer cleared; pending pushes discarded.

Test Plan:
- Buffer all zero, start → no FIFO_w_en_o; spikecore_done_o pulse in cycle 17; spike_count_o=0; busy_o high in cycles 1-17.
- Word0=0x0000_0005, word7=0x8000_0000, FIFO never full → pushes 0, 2, 255 in that order; done in cycle 20; spike_count_o=3; buffer reads back zero afterwards.
- All 8 words 0xFFFF_FFFF → 256 consecutive-index pushes 0..255; spike_count_o=256; done in cycle 273.
- Word3=0x0000_0011, FIFO_full_i high for 4 cycles starting at the first SCAN3 cycle → no push while full; then pushes 96 and 100; done delayed by exactly 4 cycles versus the no-stall run.
- Write word2 via spk_we_i during SCAN, and pulse start_i while busy → write dropped, no second scan; after DONE, word2 is still 0 and busy_o=0.
- Assert RSTN low after 2 pushes with bits remaining → outputs return to reset values asynchronously; after release, a start with an empty buffer produces zero pushes.
